// File: rtl/seg7_pkg.sv
// Shared types and constants for the scanned seven-segment history display.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;

  localparam int unsigned NUM_DIGITS = 4;

  // Active-low {g,f,e,d,c,b,a} patterns for hex 0..F.
  localparam seg_t SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/seg7_history_scan_if.sv
// Decoder-side strobes and display pins of the history scanner.
interface seg7_history_scan_if;
  import seg7_pkg::*;

  logic       load;
  logic       clr;
  logic [3:0] data_in;
  logic       err_in;
  logic [3:0] an;
  seg_t       cathode;
  logic       dp;

  modport master (
    output load, clr, data_in, err_in,
    input  an, cathode, dp
  );

  modport slave (
    input  load, clr, data_in, err_in,
    output an, cathode, dp
  );

endinterface

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low segment pattern lookup.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seg7_history_scan.sv
// Four-deep load history scanned onto a 4-digit common-anode display.
// Define SEG7_DP_ERR_EN to light the decimal point on error-corrected words.
module seg7_history_scan
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input logic                 clk,
  input logic                 rst_n,
  seg7_history_scan_if.slave  bus
);

  localparam int unsigned DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [DIV_W-1:0]                presc_q, presc_d;
  logic                            tick;
  logic [1:0]                      idx_q, idx_d;
  logic [NUM_DIGITS-1:0][3:0]      digit_q, digit_d;
  logic [NUM_DIGITS-1:0]           valid_q, valid_d;
  logic [3:0]                      an_q;
  seg_t                            cathode_q;
  logic                            dp_q;
  seg_t                            seg_cur;

  assign tick = (presc_q == DIV_W'(REFRESH_DIV - 1));

  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    idx_d   = tick ? idx_q + 2'd1 : idx_q;
  end

  // Clear is applied before load so clr+load leaves exactly one valid entry.
  always_comb begin
    digit_d = digit_q;
    valid_d = clr_or_keep(valid_q, bus.clr);
    if (bus.load) begin
      digit_d = {digit_q[NUM_DIGITS-2:0], bus.data_in};
      valid_d = {valid_d[NUM_DIGITS-2:0], 1'b1};
    end
  end

  function automatic logic [NUM_DIGITS-1:0] clr_or_keep(logic [NUM_DIGITS-1:0] v, logic c);
    return c ? '0 : v;
  endfunction

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (digit_q[idx_q]),
    .seg    (seg_cur)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= '0;
      idx_q     <= '0;
      digit_q   <= '0;
      valid_q   <= '0;
      an_q      <= 4'b1111;
      cathode_q <= SEG_BLANK;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      digit_q   <= digit_d;
      valid_q   <= valid_d;
      an_q      <= ~(4'b0001 << idx_q);
      cathode_q <= valid_q[idx_q] ? seg_cur : SEG_BLANK;
    end
  end

`ifdef SEG7_DP_ERR_EN
  logic [NUM_DIGITS-1:0] errflag_q, errflag_d;

  always_comb begin
    errflag_d = clr_or_keep(errflag_q, bus.clr);
    if (bus.load) begin
      errflag_d = {errflag_d[NUM_DIGITS-2:0], bus.err_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      errflag_q <= '0;
      dp_q      <= 1'b1;
    end else begin
      errflag_q <= errflag_d;
      dp_q      <= ~(valid_q[idx_q] & errflag_q[idx_q]);
    end
  end
`else
  logic unused_err;
  assign unused_err = bus.err_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_q <= 1'b1;
    end else begin
      dp_q <= 1'b1;
    end
  end
`endif

  assign bus.an      = an_q;
  assign bus.cathode = cathode_q;
  assign bus.dp      = dp_q;

endmodule

// File: tb/tb_seg7_history_scan.sv
// Randomized and directed bench for seg7_history_scan against a queue-based history model.
module tb_seg7_history_scan;

  localparam int unsigned DIV = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_history_scan_if bus ();

  seg7_history_scan #(.REFRESH_DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] v;
    logic       e;
  } ent_t;

  logic [6:0] seg_ref [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  ent_t        hist[$];      // newest first; position i is digit i
  int unsigned k;            // clock edges since reset release
  logic [3:0]  exp_an;
  logic [6:0]  exp_cath;
  logic        exp_dp;
  int          total = 0;
  int          bad = 0;

  task automatic model_reset();
    hist.delete();
    k        = 0;
    exp_an   = 4'b1111;
    exp_cath = 7'b1111111;
    exp_dp   = 1'b1;
  endtask

  // One clock: the model predicts the pins from the pre-edge history and slot, then applies
  // clr/load. Returns at the following falling edge for sampling and driving.
  task automatic step();
    int   idx;
    ent_t ent;
    @(posedge clk);
    if (rst_n) begin
      idx    = int'((k / DIV) % 4);
      exp_an = 4'(~(4'b0001 << idx));
      if (idx < hist.size()) begin
        exp_cath = seg_ref[hist[idx].v];
`ifdef SEG7_DP_ERR_EN
        exp_dp = ~hist[idx].e;
`else
        exp_dp = 1'b1;
`endif
      end else begin
        exp_cath = 7'b1111111;
        exp_dp   = 1'b1;
      end
      if (bus.clr) hist.delete();
      if (bus.load) begin
        ent.v = bus.data_in;
        ent.e = bus.err_in;
        hist.push_front(ent);
        if (hist.size() > 4) void'(hist.pop_back());
      end
      k++;
    end
    @(negedge clk);
  endtask

  task automatic load_one(input logic [3:0] v, input logic e);
    bus.load = 1'b1; bus.data_in = v; bus.err_in = e;
    step();
    bus.load = 1'b0; bus.err_in = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    repeat (3) step();
    total += 3;
    if (bus.an !== 4'b1111) begin bad++; $display("FAIL reset_an got=%b want=1111", bus.an); end
    if (bus.cathode !== 7'b1111111) begin
      bad++; $display("FAIL reset_cathode got=%b want=1111111", bus.cathode);
    end
    if (bus.dp !== 1'b1) begin bad++; $display("FAIL reset_dp got=%b want=1", bus.dp); end
    rst_n = 1'b1;
    step();
    total += 2;
    if (bus.an !== 4'b1110) begin bad++; $display("FAIL first_slot_an got=%b want=1110", bus.an); end
    if (bus.cathode !== 7'b1111111) begin
      bad++; $display("FAIL first_slot_blank got=%b want=1111111", bus.cathode);
    end
  endtask

  task automatic test_load_seq();
    logic [6:0] want;
    for (int i = 1; i <= 4; i++) load_one(4'(i), 1'b0);
    repeat (16) begin
      step();
      total += 2;
      if (bus.an !== exp_an || bus.cathode !== exp_cath) begin
        bad++; $display("FAIL load_seq_model an=%b cath=%b want an=%b cath=%b",
                        bus.an, bus.cathode, exp_an, exp_cath);
      end
      unique case (bus.an)
        4'b1110: want = 7'b0011001;
        4'b1101: want = 7'b0110000;
        4'b1011: want = 7'b0100100;
        4'b0111: want = 7'b1111001;
        default: want = 7'bx;
      endcase
      if (bus.cathode !== want) begin
        bad++; $display("FAIL load_seq_slot an=%b got=%b want=%b", bus.an, bus.cathode, want);
      end
    end
  endtask

  task automatic test_wrap();
    int wraps = 0;
    logic [3:0] prev_an;
    load_one(4'hF, 1'b0);
    prev_an = bus.an;
    repeat (32) begin
      step();
      total++;
      if (bus.an !== exp_an || bus.cathode !== exp_cath) begin
        bad++; $display("FAIL wrap_model an=%b cath=%b want an=%b cath=%b",
                        bus.an, bus.cathode, exp_an, exp_cath);
      end
      if (prev_an == 4'b0111 && bus.an == 4'b1110) wraps++;
      prev_an = bus.an;
      if (bus.an == 4'b1110) begin
        total++;
        if (bus.cathode !== 7'b0001110) begin
          bad++; $display("FAIL wrap_newest got=%b want=0001110", bus.cathode);
        end
      end
      if (bus.an == 4'b0111) begin
        total++;
        if (bus.cathode !== 7'b0100100) begin
          bad++; $display("FAIL wrap_oldest got=%b want=0100100", bus.cathode);
        end
      end
    end
    total++;
    if (wraps != 2) begin bad++; $display("FAIL wrap_count got=%0d want=2", wraps); end
  endtask

  task automatic test_tick_load();
    int guard = 0;
    while ((k % DIV) != DIV - 1 && guard < 2 * DIV) begin step(); guard++; end
    load_one(4'hA, 1'b0);
    step();
    total++;
    if (bus.an !== exp_an || bus.cathode !== exp_cath) begin
      bad++; $display("FAIL tick_load_next an=%b cath=%b want an=%b cath=%b",
                      bus.an, bus.cathode, exp_an, exp_cath);
    end
    repeat (16) begin
      step();
      if (bus.an == 4'b1110) begin
        total++;
        if (bus.cathode !== 7'b0001000) begin
          bad++; $display("FAIL tick_load_digit got=%b want=0001000", bus.cathode);
        end
      end
    end
  endtask

  task automatic test_clr_load();
    logic [6:0] want;
    bus.clr = 1'b1;
    load_one(4'h8, 1'b0);
    bus.clr = 1'b0;
    repeat (16) begin
      step();
      want = (bus.an == 4'b1110) ? 7'b0000000 : 7'b1111111;
      total += 2;
      if (bus.cathode !== want) begin
        bad++; $display("FAIL clr_load an=%b got=%b want=%b", bus.an, bus.cathode, want);
      end
      if (bus.an !== exp_an) begin
        bad++; $display("FAIL clr_load_an got=%b want=%b", bus.an, exp_an);
      end
    end
  endtask

  task automatic test_async_reset();
    int guard = 0;
    for (int i = 0; i < 4; i++) load_one(4'($urandom_range(0, 15)), 1'b0);
    while (((k / DIV) % 4) != 2 && guard < 32) begin step(); guard++; end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    total += 3;
    if (bus.an !== 4'b1111) begin bad++; $display("FAIL async_an got=%b want=1111", bus.an); end
    if (bus.cathode !== 7'b1111111) begin
      bad++; $display("FAIL async_cathode got=%b want=1111111", bus.cathode);
    end
    if (bus.dp !== 1'b1) begin bad++; $display("FAIL async_dp got=%b want=1", bus.dp); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    total += 2;
    if (bus.an !== 4'b1110) begin bad++; $display("FAIL restart_an got=%b want=1110", bus.an); end
    if (bus.cathode !== 7'b1111111) begin
      bad++; $display("FAIL restart_blank got=%b want=1111111", bus.cathode);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.load    = ($urandom_range(0, 3) == 0);
      bus.clr     = ($urandom_range(0, 15) == 0);
      bus.data_in = 4'($urandom_range(0, 15));
      bus.err_in  = 1'($urandom_range(0, 1));
      step();
      total++;
      if (bus.an !== exp_an || bus.cathode !== exp_cath || bus.dp !== exp_dp) begin
        bad++; $display("FAIL random cyc=%0d an=%b cath=%b dp=%b want an=%b cath=%b dp=%b",
                        i, bus.an, bus.cathode, bus.dp, exp_an, exp_cath, exp_dp);
      end
    end
    bus.load = 1'b0; bus.clr = 1'b0; bus.err_in = 1'b0;
  endtask

  task automatic test_dp();
    logic want;
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    load_one(4'h5, 1'b1);
    load_one(4'h6, 1'b0);
    repeat (2) step();
    repeat (16) begin
      step();
`ifdef SEG7_DP_ERR_EN
      want = (bus.an == 4'b1101) ? 1'b0 : 1'b1;
`else
      want = 1'b1;
`endif
      total += 2;
      if (bus.dp !== want) begin
        bad++; $display("FAIL dp an=%b got=%b want=%b", bus.an, bus.dp, want);
      end
      if (bus.dp !== exp_dp) begin
        bad++; $display("FAIL dp_model an=%b got=%b want=%b", bus.an, bus.dp, exp_dp);
      end
    end
  endtask

  initial begin
    bus.load = 1'b0; bus.clr = 1'b0; bus.data_in = 4'h0; bus.err_in = 1'b0;
    @(negedge clk);
    test_reset();
    test_load_seq();
    test_wrap();
    test_tick_load();
    test_clr_load();
    test_async_reset();
    test_random();
    test_dp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
